hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Generates the registered forward_a/forward_b selects consumed by the EX stage.
- Detects load-use hazards and inserts a one-cycle bubble; flushes on a taken branch resolved in EX.
- Owns the multi-cycle multiply/divide sequencer and stalls ID while a result is pending.

Parameters:
- MULDIV_CYCLES, 32, number of EX cycles a mult/div occupies (≥2).
- REG_W, 5, register-specifier width.

Ports:
- clk  input  1  pipeline clock.
- rst_n  input  1  synchronous, active-low reset.
- id_rs  input  REG_W  rs field of instruction in ID.
- id_rt  input  REG_W  rt field of instruction in ID.
- id_uses_rs  input  1  ID instruction reads rs.
- id_uses_rt  input  1  ID instruction reads rt.
- id_muldiv  input  1  ID instruction is mult/div/mfhi/mflo.
- ex_regdst  input  REG_W  destination of instruction in EX.
- ex_reg_write  input  1  EX instruction writes a register.
- ex_mem_read  input  1  EX instruction is a load.
- ex_muldiv_start  input  1  mult/div entering EX this cycle.
- mem_regdst  input  REG_W  destination in MEM.
- mem_reg_write  input  1  MEM instruction writes a register.
- branch_taken_ex  input  1  taken branch/jump resolved in EX.
- forward_a  output  2  rs operand select for EX: 00 regfile, 01 MEM/WB result, 10 EX/MEM result.
- forward_b  output  2  rt operand select, same encoding.
- pc_write  output  1  PC register enable.
- if_id_write  output  1  IF/ID register enable.
- if_id_flush  output  1  zero IF/ID.
- id_ex_flush  output  1  load bubble into ID/EX.
- muldiv_busy  output  1  sequencer in BUSY.
- muldiv_done  output  1  one-cycle pulse, HI/LO valid.

Behaviour:
- Clocking and reset:
  - All state updates on posedge clk.
  - While rst_n=0 at an edge: forward_a=forward_b=00, FSM→IDLE, counter=0, muldiv_done=0.
  - While rst_n=0 the combinational outputs are forced to pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1.
  - Reset during BUSY aborts the operation; no done pulse is produced.
- Forward selects (registered, 1-cycle latency):
  - Computed from the ID instruction and loaded at the edge at which that instruction enters EX.
  - The ID instruction's producers at that point are the current EX instruction (moving to MEM) and the current MEM instruction (moving to WB).
  - forward_a next = 10 if id_uses_rs & ex_reg_write & ex_regdst==id_rs & id_rs!=0.
  - Otherwise 01 if id_uses_rs & mem_reg_write & mem_regdst==id_rs & id_rs!=0.
  - Otherwise 00.
  - forward_b is computed the same way with id_rt/id_uses_rt.
  - The EX/MEM match takes priority when both match.
  - On any edge where id_ex_flush=1, both selects load 00.
  - The register file is write-first, so no WB-stage compare is needed.
- Load-use stall (combinational):
  - ld_use = ex_mem_read & ex_reg_write & ex_regdst!=0 & ((id_uses_rs & ex_regdst==id_rs) | (id_uses_rt & ex_regdst==id_rt)).
- Mult/div FSM states:
  - IDLE: on ex_muldiv_start, go to BUSY and load counter=MULDIV_CYCLES-1.
  - BUSY: decrement the counter each cycle; at counter==0, go to DONE.
  - DONE: muldiv_done=1 for exactly one cycle, then IDLE. A new ex_muldiv_start in DONE re-enters BUSY directly.
  - md_stall = id_muldiv & (state==BUSY | ex_muldiv_start).
  - A start pulse outside IDLE/DONE cannot occur because ID is stalled; it is ignored if it does.
- Stall/flush priority, branch_taken_ex highest:
  - branch_taken_ex: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1. Redirect wins over any stall; the stalled ID instruction is discarded.
  - Otherwise, if ld_use|md_stall: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_flush=1.
  - Otherwise: pc_write=1, if_id_write=1, both flushes=0.
- Simultaneous ld_use and md_stall produce a single stall; the hazard is re-evaluated every cycle.
- muldiv_busy = (state==BUSY).

Test Plan:
- Reset: hold rst_n=0 for 2 cycles → pc_write=0, both flushes=1, forward_a/b=00. Release rst_n → pc_write=1, flushes=0.
- Back-to-back ALU dependency: EX writes $3, ID reads rs=$3 → next cycle forward_a=10. Same with MEM writing $3 and EX not → forward_a=01. Both EX and MEM writing $3 → 10. Destination $0 → 00.
- Load-use: ex_mem_read=1, ex_regdst=$5, ID rt=$5 with id_uses_rt=1 → one cycle pc_write=0, if_id_write=0, id_ex_flush=1. Next cycle (load now in MEM) → no stall, forward_b=01.
- Mult/div with MULDIV_CYCLES=4: ex_muldiv_start → muldiv_busy=1 for 4 cycles, then muldiv_done=1 for 1 cycle. An mflo in ID is stalled through BUSY and released in the DONE cycle.
- Branch during stall: ld_use active and branch_taken_ex=1 → pc_write=1, if_id_flush=1, id_ex_flush=1. Forward selects load 00.
- Reset in BUSY: rst_n=0 at counter=2 → IDLE next edge, muldiv_busy=0, no muldiv_done pulse.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: registered EX forward selects, load-use and mult/div
// stalls, branch flush, and the multi-cycle mult/div sequencer.
module hazard_unit #(
    parameter int MULDIV_CYCLES = 32,
    parameter int REG_W         = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_muldiv,
    input  logic [REG_W-1:0] ex_regdst,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_muldiv_start,
    input  logic [REG_W-1:0] mem_regdst,
    input  logic             mem_reg_write,
    input  logic             branch_taken_ex,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             muldiv_busy,
    output logic             muldiv_done
);

    localparam int CNT_W = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;
    logic             ld_use;
    logic             md_stall;

    // EX/MEM producer beats MEM/WB; $0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic             uses,
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] ex_dst,
        input logic             ex_wr,
        input logic [REG_W-1:0] mem_dst,
        input logic             mem_wr
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (uses && (src != '0)) begin
            if (ex_wr && (ex_dst == src)) begin
                sel = 2'b10;
            end else if (mem_wr && (mem_dst == src)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (ex_muldiv_start) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (ex_muldiv_start) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign ld_use = ex_mem_read && ex_reg_write && (ex_regdst != '0) &&
                    ((id_uses_rs && (ex_regdst == id_rs)) ||
                     (id_uses_rt && (ex_regdst == id_rt)));

    assign md_stall = id_muldiv && ((state_q == S_BUSY) || ex_muldiv_start);

    // Redirect outranks any stall; reset holds the front end frozen and flushed.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (!rst_n) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (branch_taken_ex) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (ld_use || md_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        if (!id_ex_flush) begin
            fwd_a_d = fwd_sel(id_uses_rs, id_rs, ex_regdst, ex_reg_write,
                              mem_regdst, mem_reg_write);
            fwd_b_d = fwd_sel(id_uses_rt, id_rt, ex_regdst, ex_reg_write,
                              mem_regdst, mem_reg_write);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign forward_a   = fwd_a_q;
    assign forward_b   = fwd_b_q;
    assign muldiv_busy = (state_q == S_BUSY);
    assign muldiv_done = (state_q == S_DONE);

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: vector table with a forward-select
// scoreboard, plus reset, mult/div and reset-during-BUSY sequences.
module tb_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs, id_rt;
    logic       id_uses_rs, id_uses_rt, id_muldiv;
    logic [4:0] ex_regdst;
    logic       ex_reg_write, ex_mem_read, ex_muldiv_start;
    logic [4:0] mem_regdst;
    logic       mem_reg_write, branch_taken_ex;
    logic [1:0] forward_a, forward_b;
    logic       pc_write, if_id_write, if_id_flush, id_ex_flush;
    logic       muldiv_busy, muldiv_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [4:0] id_rs, id_rt;
        logic       uses_rs, uses_rt;
        logic [4:0] ex_regdst;
        logic       ex_rw, ex_mr;
        logic [4:0] mem_regdst;
        logic       mem_rw, br;
        logic [3:0] exp_ctl;
        logic [1:0] exp_fa, exp_fb;
    } vec_t;

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
    } fwd_exp_t;

    vec_t     vecs[14];
    fwd_exp_t sb_q[$];

    hazard_unit #(.MULDIV_CYCLES(4), .REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_muldiv(id_muldiv),
        .ex_regdst(ex_regdst), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_muldiv_start(ex_muldiv_start),
        .mem_regdst(mem_regdst), .mem_reg_write(mem_reg_write),
        .branch_taken_ex(branch_taken_ex),
        .forward_a(forward_a), .forward_b(forward_b),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    function automatic vec_t mk(input string n,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt,
                                input logic [4:0] exd, input logic exw, input logic exm,
                                input logic [4:0] memd, input logic memw, input logic br,
                                input logic [3:0] ctl, input logic [1:0] fa, input logic [1:0] fb);
        vec_t v;
        v.name = n; v.id_rs = rs; v.id_rt = rt; v.uses_rs = urs; v.uses_rt = urt;
        v.ex_regdst = exd; v.ex_rw = exw; v.ex_mr = exm;
        v.mem_regdst = memd; v.mem_rw = memw; v.br = br;
        v.exp_ctl = ctl; v.exp_fa = fa; v.exp_fb = fb;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic driveIdle();
        id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_muldiv = 1'b0;
        ex_regdst = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_muldiv_start = 1'b0;
        mem_regdst = '0; mem_reg_write = 1'b0; branch_taken_ex = 1'b0;
    endtask

    function automatic logic [7:0] ctl();
        return {4'b0, pc_write, if_id_write, if_id_flush, id_ex_flush};
    endfunction

    // Control outputs are checked before the edge; forward selects one edge later.
    task automatic applyStimulus(input vec_t v);
        fwd_exp_t e;
        @(negedge clk);
        driveIdle();
        id_rs = v.id_rs; id_rt = v.id_rt; id_uses_rs = v.uses_rs; id_uses_rt = v.uses_rt;
        ex_regdst = v.ex_regdst; ex_reg_write = v.ex_rw; ex_mem_read = v.ex_mr;
        mem_regdst = v.mem_regdst; mem_reg_write = v.mem_rw; branch_taken_ex = v.br;
        #1;
        checkOutput({v.name, "_ctl"}, ctl(), {4'b0, v.exp_ctl});
        sb_q.push_back('{fa: v.exp_fa, fb: v.exp_fb});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        checkOutput({v.name, "_fa"}, {6'b0, forward_a}, {6'b0, e.fa});
        checkOutput({v.name, "_fb"}, {6'b0, forward_b}, {6'b0, e.fb});
    endtask

    initial begin
        vecs[0]  = mk("ex_fwd_rs",      3, 0, 1, 0, 3, 1, 0, 0, 0, 0, 4'b1100, 2'b10, 2'b00);
        vecs[1]  = mk("mem_fwd_rs",     3, 0, 1, 0, 4, 1, 0, 3, 1, 0, 4'b1100, 2'b01, 2'b00);
        vecs[2]  = mk("both_fwd_rs",    3, 0, 1, 0, 3, 1, 0, 3, 1, 0, 4'b1100, 2'b10, 2'b00);
        vecs[3]  = mk("zero_dst",       0, 0, 1, 1, 0, 1, 0, 0, 1, 0, 4'b1100, 2'b00, 2'b00);
        vecs[4]  = mk("ex_fwd_rt",      7, 7, 0, 1, 7, 1, 0, 7, 1, 0, 4'b1100, 2'b00, 2'b10);
        vecs[5]  = mk("mem_fwd_rt",     1, 9, 1, 1, 2, 1, 0, 9, 1, 0, 4'b1100, 2'b00, 2'b01);
        vecs[6]  = mk("no_write",       6, 6, 1, 1, 6, 0, 0, 6, 0, 0, 4'b1100, 2'b00, 2'b00);
        vecs[7]  = mk("load_use_rt",    1, 5, 1, 1, 5, 1, 1, 0, 0, 0, 4'b0001, 2'b00, 2'b00);
        vecs[8]  = mk("load_in_mem",    1, 5, 1, 1, 2, 1, 0, 5, 1, 0, 4'b1100, 2'b00, 2'b01);
        vecs[9]  = mk("load_rt_unused", 1, 5, 1, 0, 5, 1, 1, 0, 0, 0, 4'b1100, 2'b00, 2'b00);
        vecs[10] = mk("load_use_rs",    8, 2, 1, 0, 8, 1, 1, 0, 0, 0, 4'b0001, 2'b00, 2'b00);
        vecs[11] = mk("load_zero_dst",  0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 4'b1100, 2'b00, 2'b00);
        vecs[12] = mk("branch_ld_use",  5, 5, 1, 1, 5, 1, 1, 5, 1, 1, 4'b1111, 2'b00, 2'b00);
        vecs[13] = mk("branch_fwd",     3, 4, 1, 1, 3, 1, 0, 4, 1, 1, 4'b1111, 2'b00, 2'b00);

        // Reset with forwarding-eligible inputs present: selects must stay 00.
        rst_n = 1'b0;
        driveIdle();
        id_rs = 5'd3; id_uses_rs = 1'b1; ex_regdst = 5'd3; ex_reg_write = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ctl", ctl(), 8'h03);
        checkOutput("reset_fa", {6'b0, forward_a}, 8'h00);
        checkOutput("reset_fb", {6'b0, forward_b}, 8'h00);
        checkOutput("reset_busy", {7'b0, muldiv_busy}, 8'h00);
        checkOutput("reset_done", {7'b0, muldiv_done}, 8'h00);
        driveIdle();
        rst_n = 1'b1;
        #1;
        checkOutput("release_ctl", ctl(), 8'h0c);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // mflo in ID while its mult starts, then through BUSY until DONE.
        @(negedge clk);
        driveIdle();
        ex_muldiv_start = 1'b1; id_muldiv = 1'b1;
        #1;
        checkOutput("md_start_ctl", ctl(), 8'h01);
        checkOutput("md_start_busy", {7'b0, muldiv_busy}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ex_muldiv_start = 1'b0;
            #1;
            checkOutput($sformatf("md_busy%0d", i), {7'b0, muldiv_busy}, 8'h01);
            checkOutput($sformatf("md_nodone%0d", i), {7'b0, muldiv_done}, 8'h00);
            checkOutput($sformatf("md_stall%0d", i), ctl(), 8'h01);
        end
        @(negedge clk);
        #1;
        checkOutput("md_done", {7'b0, muldiv_done}, 8'h01);
        checkOutput("md_done_busy", {7'b0, muldiv_busy}, 8'h00);
        checkOutput("md_release_ctl", ctl(), 8'h0c);
        @(negedge clk);
        driveIdle();
        #1;
        checkOutput("md_idle_done", {7'b0, muldiv_done}, 8'h00);
        checkOutput("md_idle_busy", {7'b0, muldiv_busy}, 8'h00);

        // Second op, restarted straight from DONE.
        @(negedge clk);
        ex_muldiv_start = 1'b1;
        @(negedge clk);
        ex_muldiv_start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("md2_last_busy", {7'b0, muldiv_busy}, 8'h01);
        @(negedge clk);
        ex_muldiv_start = 1'b1; id_muldiv = 1'b1;
        #1;
        checkOutput("md2_done", {7'b0, muldiv_done}, 8'h01);
        checkOutput("md2_restart_ctl", ctl(), 8'h01);
        @(negedge clk);
        driveIdle();
        #1;
        checkOutput("md3_busy", {7'b0, muldiv_busy}, 8'h01);
        checkOutput("md3_nodone", {7'b0, muldiv_done}, 8'h00);

        // Counter now 2: reset aborts the op with no done pulse.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("md_rst_ctl", ctl(), 8'h03);
        checkOutput("md_rst_busy_pre", {7'b0, muldiv_busy}, 8'h01);
        @(negedge clk);
        checkOutput("md_rst_busy", {7'b0, muldiv_busy}, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("md_rst_nodone%0d", i), {6'b0, muldiv_busy, muldiv_done}, 8'h00);
        end

        checkOutput("sb_empty", 8'(sb_q.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
